// File: rtl/i2c_master_arbiter_if.sv
// Handshake bundle between NUM_REQ requesters, the arbiter and one I2C byte-write master.
// The master modport is the arbiter's view; slave is the environment's view.
interface i2c_master_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]   req_valid;
  logic [7*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic [NUM_REQ-1:0]   req_done;
  logic [NUM_REQ-1:0]   req_err;
  logic                 m_start;
  logic [6:0]           m_addr;
  logic [7:0]           m_data;
  logic                 m_ready;

  modport master (
    input  req_valid, req_addr, req_data, m_ready,
    output req_ack, req_done, req_err, m_start, m_addr, m_data
  );

  modport slave (
    output req_valid, req_addr, req_data, m_ready,
    input  req_ack, req_done, req_err, m_start, m_addr, m_data
  );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C byte-write master between NUM_REQ requesters,
// with a per-transaction watchdog that converts a stalled master into an error pulse.
module i2c_master_arbiter #(
  parameter int   NUM_REQ        = 4,
  parameter int   TIMEOUT_CYCLES = 65535,
  localparam int  RW             = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  i2c_master_arbiter_if.master  bus,
  output logic                  busy,
  output logic [RW-1:0]         owner
);
  localparam int            WW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [WW-1:0]      wd_q, wd_d, wd_inc;
  logic [RW-1:0]      owner_q, owner_d;
  logic [RW-1:0]      last_grant_q, last_grant_d;
  logic [6:0]         m_addr_q, m_addr_d;
  logic [7:0]         m_data_q, m_data_d;
  logic               m_start_q, m_start_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;

  logic [RW-1:0]      winner, idx;
  logic               found, grant;
  logic [6:0]         sel_addr;
  logic [7:0]         sel_data;
  logic [NUM_REQ-1:0] winner_hot, owner_hot;

  // Search from the requester after the last one served, wrapping once round.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = RW'((int'(last_grant_q) + i) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    sel_addr   = '0;
    sel_data   = '0;
    winner_hot = '0;
    owner_hot  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (RW'(i) == winner) begin
        sel_addr      = bus.req_addr[7*i +: 7];
        sel_data      = bus.req_data[8*i +: 8];
        winner_hot[i] = 1'b1;
      end
      if (RW'(i) == owner_q) begin
        owner_hot[i] = 1'b1;
      end
    end
  end

  // No grant while a done/err pulse is out, so IDLE always lasts at least one cycle.
  assign grant  = reset && (state_q == IDLE) && bus.m_ready && found &&
                  (done_q == '0) && (err_q == '0);
  assign wd_inc = (wd_q == WD_MAX) ? wd_q : wd_q + WW'(1);

  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    m_addr_d     = m_addr_q;
    m_data_d     = m_data_q;
    m_start_d    = 1'b0;
    done_d       = '0;
    err_d        = '0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d   = ISSUE;
          owner_d   = winner;
          m_addr_d  = sel_addr;
          m_data_d  = sel_data;
          m_start_d = 1'b1;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        wd_d = wd_inc;
        // A completion or acceptance in the expiry cycle still counts as on time.
        if (state_q == WAIT_DONE && bus.m_ready) begin
          done_d       = owner_hot;
          last_grant_d = owner_q;
          state_d      = IDLE;
        end else if (state_q == WAIT_BUSY && !bus.m_ready) begin
          state_d = WAIT_DONE;
        end else if (wd_inc == WD_MAX) begin
          err_d        = owner_hot;
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      wd_q         <= '0;
      owner_q      <= '0;
      last_grant_q <= RW'(NUM_REQ - 1);
      m_addr_q     <= '0;
      m_data_q     <= '0;
      m_start_q    <= 1'b0;
      done_q       <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      m_addr_q     <= m_addr_d;
      m_data_q     <= m_data_d;
      m_start_q    <= m_start_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.req_ack  = grant ? winner_hot : '0;
  assign bus.req_done = done_q;
  assign bus.req_err  = err_q;
  assign bus.m_start  = m_start_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_data   = m_data_q;
  assign busy         = (state_q != IDLE);
  assign owner        = owner_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: requester and master models drive the bus each
// cycle, and a scoreboard of expected grants/completions checks every pulse the DUT emits.
module tb_i2c_master_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;

  typedef struct {
    int idx;
    bit err;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       busy;
  logic [1:0] owner;

  i2c_master_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  i2c_master_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  exp_t       exp_ack_q[$];
  exp_t       exp_end_q[$];
  logic [3:0] valid_reg;
  int         grants_left[4];
  logic [6:0] addr_tab[4];
  logic [7:0] data_tab[4];
  int         done_cnt[4];
  int         mstr_mode;
  int         mstr_cnt;
  int         busy_len;
  logic       manual_ready;
  logic [3:0] obs_ack, obs_done, obs_err;
  logic       obs_start, obs_busy;
  logic [1:0] obs_owner;
  logic [6:0] obs_addr;
  logic [7:0] obs_data;
  bit         start_pending;
  logic [6:0] exp_addr;
  logic [7:0] exp_data;
  int         last_start_cycle;
  int         last_end_cycle;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] onehot(input int i);
    onehot = 4'b0001 << i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard and requester/master reactions to what the DUT showed this cycle.
  task automatic checkOutput();
    exp_t e;
    if (start_pending) begin
      chk("m_start", 32'(obs_start), 32'd1);
      chk("m_addr", 32'(obs_addr), 32'(exp_addr));
      chk("m_data", 32'(obs_data), 32'(exp_data));
      start_pending = 1'b0;
    end else begin
      chk("start_spurious", 32'(obs_start), 32'd0);
    end
    if (obs_start) begin
      last_start_cycle = cyc;
      if (mstr_mode == 0) mstr_cnt = busy_len;
    end
    if (obs_ack != 4'b0) begin
      if (exp_ack_q.size() == 0) begin
        chk("ack_unexpected", 32'(obs_ack), 32'd0);
      end else begin
        e = exp_ack_q.pop_front();
        chk("ack", 32'(obs_ack), 32'(onehot(e.idx)));
        exp_end_q.push_back(e);
        start_pending = 1'b1;
        exp_addr = addr_tab[e.idx];
        exp_data = data_tab[e.idx];
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (obs_ack[i]) begin
          grants_left[i]--;
          if (grants_left[i] <= 0) begin
            valid_reg[i] = 1'b0;
          end else begin
            addr_tab[i] = addr_tab[i] + 7'd1;
            data_tab[i] = data_tab[i] ^ 8'h5A;
          end
        end
      end
    end
    if (obs_done != 4'b0 || obs_err != 4'b0) begin
      last_end_cycle = cyc;
      for (int i = 0; i < NUM_REQ; i++) if (obs_done[i]) done_cnt[i]++;
      if (exp_end_q.size() == 0) begin
        chk("done_unexpected", 32'(obs_done), 32'd0);
        chk("err_unexpected", 32'(obs_err), 32'd0);
      end else begin
        e = exp_end_q.pop_front();
        chk("done", 32'(obs_done), e.err ? 32'd0 : 32'(onehot(e.idx)));
        chk("err", 32'(obs_err), e.err ? 32'(onehot(e.idx)) : 32'd0);
        chk("end_owner", 32'(obs_owner), 32'(e.idx));
        chk("end_ack_excl", 32'(obs_ack), 32'd0);
        chk("end_busy", 32'(obs_busy), 32'd0);
      end
    end
  endtask

  // One clock cycle: drive inputs just after the edge, sample outputs mid-cycle.
  task automatic applyStimulus(input logic rst_n);
    @(posedge clk);
    #1;
    cyc++;
    reset = rst_n;
    case (mstr_mode)
      0: begin
        if (mstr_cnt > 0) begin
          bus.m_ready = 1'b0;
          mstr_cnt--;
        end else begin
          bus.m_ready = 1'b1;
        end
      end
      1:       bus.m_ready = 1'b1;
      default: bus.m_ready = manual_ready;
    endcase
    bus.req_valid = valid_reg;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[7*i +: 7] = addr_tab[i];
      bus.req_data[8*i +: 8] = data_tab[i];
    end
    #2;
    obs_ack   = bus.req_ack;
    obs_done  = bus.req_done;
    obs_err   = bus.req_err;
    obs_start = bus.m_start;
    obs_addr  = bus.m_addr;
    obs_data  = bus.m_data;
    obs_busy  = busy;
    obs_owner = owner;
    checkOutput();
  endtask

  task automatic waitDrain(input string tag, input int budget);
    for (int n = 0; n < budget && (exp_ack_q.size() > 0 || exp_end_q.size() > 0 || start_pending); n++)
      applyStimulus(1'b1);
    chk(tag, 32'(exp_ack_q.size() + exp_end_q.size()), 32'd0);
  endtask

  task automatic waitStart(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      applyStimulus(1'b1);
      if (obs_start) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic pushAck(input int idx, input bit err);
    exp_t e;
    e.idx = idx;
    e.err = err;
    exp_ack_q.push_back(e);
  endtask

  initial begin
    int  fair_acks;
    int  bad;
    bit  seen;
    reset         = 1'b0;
    bus.m_ready   = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    valid_reg     = '0;
    mstr_mode     = 0;
    mstr_cnt      = 0;
    busy_len      = 3;
    manual_ready  = 1'b1;
    start_pending = 1'b0;
    exp_addr      = '0;
    exp_data      = '0;
    last_start_cycle = 0;
    last_end_cycle   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grants_left[i] = 0;
      addr_tab[i]    = '0;
      data_tab[i]    = '0;
      done_cnt[i]    = 0;
    end

    $display("[TB] reset state");
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    chk("rst_busy", 32'(obs_busy), 32'd0);
    chk("rst_owner", 32'(obs_owner), 32'd0);
    chk("rst_addr", 32'(obs_addr), 32'd0);
    chk("rst_data", 32'(obs_data), 32'd0);

    $display("[TB] single request from requester 2");
    addr_tab[2]    = 7'h50;
    data_tab[2]    = 8'hA5;
    grants_left[2] = 1;
    valid_reg      = 4'b0100;
    pushAck(2, 1'b0);
    applyStimulus(1'b1);
    chk("single_ack_same_cycle", 32'(obs_ack), 32'h4);
    waitDrain("single_drain", 50);

    $display("[TB] fairness with all requesters held");
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_tab[i] = 7'h10 + 7'(i);
      data_tab[i] = 8'h30 + 8'(i);
      done_cnt[i] = 0;
    end
    grants_left = '{2, 1, 1, 1};
    pushAck(0, 1'b0);
    pushAck(1, 1'b0);
    pushAck(2, 1'b0);
    pushAck(3, 1'b0);
    pushAck(0, 1'b0);
    valid_reg = 4'b1111;
    fair_acks = 0;
    for (int n = 0; n < 200 && (exp_ack_q.size() > 0 || exp_end_q.size() > 0); n++) begin
      applyStimulus(1'b1);
      if (obs_ack != 4'b0) begin
        if (fair_acks > 0) chk("fair_gap", cyc - last_end_cycle, 1);
        fair_acks++;
      end
    end
    chk("fair_drain", 32'(exp_ack_q.size() + exp_end_q.size()), 32'd0);
    chk("fair_done0", done_cnt[0], 2);
    chk("fair_done1", done_cnt[1], 1);
    chk("fair_done2", done_cnt[2], 1);
    chk("fair_done3", done_cnt[3], 1);

    $display("[TB] request rising with a done pulse");
    addr_tab[0]    = 7'h2C;
    data_tab[0]    = 8'hC3;
    addr_tab[1]    = 7'h61;
    data_tab[1]    = 8'h9E;
    grants_left[0] = 1;
    valid_reg      = 4'b0001;
    pushAck(0, 1'b0);
    pushAck(1, 1'b0);
    waitStart("sim_start", 10);
    repeat (busy_len + 1) applyStimulus(1'b1);
    valid_reg[1]   = 1'b1;
    grants_left[1] = 1;
    applyStimulus(1'b1);
    chk("sim_done_cycle", 32'(obs_done), 32'h1);
    chk("sim_no_ack", 32'(obs_ack), 32'd0);
    applyStimulus(1'b1);
    chk("sim_ack_next", 32'(obs_ack), 32'h2);
    waitDrain("sim_drain", 50);

    $display("[TB] master not ready");
    mstr_mode      = 2;
    manual_ready   = 1'b0;
    addr_tab[0]    = 7'h07;
    data_tab[0]    = 8'h11;
    grants_left[0] = 1;
    valid_reg      = 4'b0001;
    pushAck(0, 1'b0);
    bad = 0;
    repeat (20) begin
      applyStimulus(1'b1);
      if (obs_ack != 4'b0 || obs_busy) bad++;
    end
    chk("nr_quiet", bad, 0);
    mstr_mode = 0;
    mstr_cnt  = 0;
    applyStimulus(1'b1);
    chk("nr_ack", 32'(obs_ack), 32'h1);
    waitDrain("nr_drain", 50);

    $display("[TB] watchdog timeout");
    mstr_mode      = 1;
    addr_tab[1]    = 7'h33;
    data_tab[1]    = 8'h44;
    addr_tab[2]    = 7'h55;
    data_tab[2]    = 8'h66;
    grants_left[1] = 1;
    grants_left[2] = 1;
    valid_reg      = 4'b0110;
    pushAck(1, 1'b1);
    pushAck(2, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      applyStimulus(1'b1);
      if (obs_err != 4'b0) begin
        seen = 1'b1;
        chk("to_latency", cyc - last_start_cycle, TIMEOUT + 1);
        mstr_mode = 0;
        mstr_cnt  = 0;
      end
    end
    chk("to_seen", 32'(seen), 32'd1);
    waitDrain("to_drain", 60);

    $display("[TB] reset in the middle of a transaction");
    busy_len       = 8;
    addr_tab[0]    = 7'h3A;
    data_tab[0]    = 8'h7E;
    grants_left[0] = 1;
    valid_reg      = 4'b0001;
    pushAck(0, 1'b0);
    waitStart("rm_start", 10);
    repeat (3) applyStimulus(1'b1);
    chk("rm_busy_before", 32'(obs_busy), 32'd1);
    exp_end_q.delete();
    for (int i = 0; i < NUM_REQ; i++) grants_left[i] = 1;
    valid_reg = 4'b1111;
    applyStimulus(1'b0);
    mstr_cnt = 0;
    applyStimulus(1'b0);
    chk("rm_ack", 32'(obs_ack), 32'd0);
    chk("rm_done", 32'(obs_done), 32'd0);
    chk("rm_err", 32'(obs_err), 32'd0);
    chk("rm_start0", 32'(obs_start), 32'd0);
    chk("rm_busy", 32'(obs_busy), 32'd0);
    chk("rm_owner", 32'(obs_owner), 32'd0);
    chk("rm_addr", 32'(obs_addr), 32'd0);
    chk("rm_data", 32'(obs_data), 32'd0);
    pushAck(0, 1'b0);
    pushAck(1, 1'b0);
    pushAck(2, 1'b0);
    pushAck(3, 1'b0);
    applyStimulus(1'b1);
    chk("rm_first_grant", 32'(obs_ack), 32'h1);
    waitDrain("rm_drain", 300);

    repeat (5) applyStimulus(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Round-robin arbiter that shares one I2C byte-write master (start/addr/data/ready handshake) between NUM_REQ independent requesters. It grants one requester at a time and latches that requester's 7-bit address and 8-bit data. It then issues a single-cycle start to the master and tracks the master's busy/done sequence on `ready`. On completion it returns a per-requester done pulse, or an error pulse if a watchdog expires. It sits between client logic (or per-client FIFOs) and the I2C master, all in the master's clock domain.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- TIMEOUT_CYCLES, 65535: watchdog limit, in clk cycles, for one transaction after start.
- RW, $clog2(NUM_REQ): width of the owner index (derived, not overridden).

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request; held high until acknowledged.
- req_addr  input  7*NUM_REQ  packed addresses; requester i uses bits [7i+6:7i].
- req_data  input  8*NUM_REQ  packed data bytes; requester i uses bits [8i+7:8i].
- req_ack  output  NUM_REQ  one-hot, 1-cycle pulse; the request has been captured.
- req_done  output  NUM_REQ  one-hot, 1-cycle pulse; the owner's transaction completed.
- req_err  output  NUM_REQ  one-hot, 1-cycle pulse; the owner's transaction timed out.
- m_start  output  1  start pulse to the master.
- m_addr  output  7  registered address to the master.
- m_data  output  8  registered data to the master.
- m_ready  input  1  master idle flag (high = idle).
- busy  output  1  high in any state other than IDLE.
- owner  output  RW  index of the current or last granted requester.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If m_ready=1 and any req_valid is set, select a winner by round-robin.
  - Search starts at (last_grant+1) mod NUM_REQ and wraps.
  - On the selection cycle: latch the winner's addr/data into m_addr/m_data, set owner, pulse req_ack[winner], go to ISSUE.
  - If m_ready=0, no grant is made, even if requests are pending.
- ISSUE: m_start=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT_BUSY.
- WAIT_BUSY: wait for m_ready=0 (master accepted), then go to WAIT_DONE.
- WAIT_DONE: wait for m_ready=1, then pulse req_done[owner], set last_grant=owner, go to IDLE.
- Watchdog:
  - Counts every cycle in WAIT_BUSY and WAIT_DONE and saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: pulse req_err[owner], set last_grant=owner, go to IDLE.
  - req_done is not pulsed for a timed-out transaction.
- The requester must drop req_valid, or present new data, in the cycle after req_ack. A req_valid still high at the next IDLE is treated as a new request.
- Requests arriving during a transaction wait. Arbitration is re-evaluated only in IDLE.
- m_addr/m_data hold their values until the next grant.
- Only one of req_ack/req_done/req_err is ever asserted per cycle, and each is one-hot.
- Reset (reset=0 at a clk edge), from any state:
  - State goes to IDLE; m_start, req_ack, req_done, req_err and busy go to 0; m_addr, m_data, owner go to 0.
  - Watchdog counter goes to 0; last_grant goes to NUM_REQ-1, so requester 0 has priority first.
  - An in-flight transaction is abandoned with no done or err pulse.

## Timing
- Grant latency: request seen in IDLE with m_ready=1 → req_ack in the same cycle → m_start one cycle later.
- Back-to-back: IDLE is always visited for at least one cycle between transactions.
  - Earliest next req_ack is the cycle after the req_done pulse.
- All outputs are registered except req_ack, which is decoded from state and winner in the grant cycle.
- Master-side contract: m_ready must fall within TIMEOUT_CYCLES of m_start. A slower master is reported via req_err.
- Edge case: m_ready never dropping (master ignored start) produces req_err after TIMEOUT_CYCLES+1 cycles from m_start.

## Test plan
- Single request: NUM_REQ=4; req_valid=4'b0100, addr 7'h50, data 8'hA5.
  - Expect: req_ack=4'b0100; next cycle m_start=1 with m_addr=7'h50, m_data=8'hA5.
  - When the model master returns ready: req_done=4'b0100, owner=2.
- Fairness: hold req_valid=4'b1111 continuously, retargeting data after each ack.
  - Expect grant order 0,1,2,3,0; each requester receives exactly one req_done per four transactions.
- Master not ready: m_ready=0 with req_valid=4'b0001 for 20 cycles.
  - Expect: no req_ack and busy=0. Raise m_ready → req_ack in the same cycle.
- Timeout: TIMEOUT_CYCLES=16; the master never drops ready after start.
  - Expect: req_err[owner] 17 cycles after m_start, no req_done, return to IDLE, next requester granted.
- Reset mid-transaction: assert reset=0 in WAIT_DONE.
  - Expect: next edge all outputs 0, busy=0, no req_done.
  - After release with req_valid=4'b1111, requester 0 is granted first.
- Simultaneous events: req_valid[1] rises in the same cycle as req_done[0].
  - Expect: the request is not acked that cycle; req_ack=4'b0010 the following cycle.
